// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: the imem read port and the decode-facing instruction port.
// master = fetch unit side, slave = memory / decode side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output id_valid,
    output id_instr,
    output id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    output id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, in-order credit-limited imem reads,
// a Q_DEPTH-entry instruction queue to decode, redirect flush and halt freeze.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned Q_DEPTH  = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         halt,
  fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(Q_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(Q_DEPTH);

  logic [31:0]   pc_reg, pc_next;
  logic          running_reg;
  logic          pend_reg, pend_next;
  logic [CW-1:0] q_count_reg, q_count_next;
  logic [CW-1:0] out_reg, out_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [PW-1:0] q_head_reg, q_head_next;
  logic [PW-1:0] q_tail_reg, q_tail_next;
  logic [PW-1:0] tag_head_reg, tag_head_next;
  logic [PW-1:0] tag_tail_reg, tag_tail_next;

  logic [31:0] q_instr_mem [Q_DEPTH];
  logic [31:0] q_pc_mem    [Q_DEPTH];
  logic [31:0] tag_mem     [Q_DEPTH];

  logic [CW:0] in_flight;
  logic        credit_ok;
  logic        issue;
  logic        grant;
  logic        rsp;
  logic        rsp_keep;
  logic        q_push;
  logic        q_pop;
  logic        id_valid_int;

  // Queued words plus reads in flight may never exceed the queue size.
  assign in_flight = {1'b0, q_count_reg} + {1'b0, out_reg};
  assign credit_ok = in_flight < DEPTH_C;

  // An ungranted request is held through halt; only redirect (or reset) withdraws it.
  assign issue    = running_reg && !redirect && (pend_reg || (!halt && credit_ok));
  assign grant    = issue && bus.imem_gnt;
  assign rsp      = bus.imem_rvalid && (out_reg != '0);
  assign rsp_keep = rsp && (discard_reg == '0);
  assign q_push   = rsp_keep && !redirect;

  assign id_valid_int = (q_count_reg != '0);
  assign q_pop        = id_valid_int && bus.id_ready;

  always_comb begin
    pend_next     = issue && !bus.imem_gnt;
    pc_next       = grant ? (pc_reg + 32'd4) : pc_reg;
    out_next      = out_reg + CW'(grant) - CW'(rsp);
    discard_next  = discard_reg - CW'(rsp && !rsp_keep);
    q_count_next  = q_count_reg + CW'(q_push) - CW'(q_pop);
    q_head_next   = q_head_reg + PW'(q_pop);
    q_tail_next   = q_tail_reg + PW'(q_push);
    tag_head_next = tag_head_reg + PW'(rsp_keep);
    tag_tail_next = tag_tail_reg + PW'(grant);
    if (redirect) begin
      // Everything still in flight belongs to the old path and is dropped on return.
      pc_next       = redirect_pc & 32'hFFFF_FFFC;
      discard_next  = out_next;
      q_count_next  = '0;
      q_head_next   = '0;
      q_tail_next   = '0;
      tag_head_next = '0;
      tag_tail_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg       <= RESET_PC;
      running_reg  <= 1'b0;
      pend_reg     <= 1'b0;
      q_count_reg  <= '0;
      out_reg      <= '0;
      discard_reg  <= '0;
      q_head_reg   <= '0;
      q_tail_reg   <= '0;
      tag_head_reg <= '0;
      tag_tail_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      running_reg  <= 1'b1;
      pend_reg     <= pend_next;
      q_count_reg  <= q_count_next;
      out_reg      <= out_next;
      discard_reg  <= discard_next;
      q_head_reg   <= q_head_next;
      q_tail_reg   <= q_tail_next;
      tag_head_reg <= tag_head_next;
      tag_tail_reg <= tag_tail_next;
    end
  end

  // Payload storage needs no reset; validity is carried by the counters and pointers.
  always_ff @(posedge clock) begin
    if (q_push) begin
      q_instr_mem[q_tail_reg] <= bus.imem_rdata;
      q_pc_mem[q_tail_reg]    <= tag_mem[tag_head_reg];
    end
    if (grant) begin
      tag_mem[tag_tail_reg] <= pc_reg;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_reg;
  assign bus.id_valid  = id_valid_int;
  assign bus.id_instr  = id_valid_int ? q_instr_mem[q_head_reg] : 32'h0;
  assign bus.id_pc     = id_valid_int ? q_pc_mem[q_head_reg]    : 32'h0;
endmodule
